bcd_seq_display: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble) feeding DIGITS seven-segment outputs.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_seq_display_seg7.sv | 18 +
 rtl/bcd_seq_display.sv | 159 +++++++++++++++
 tb/tb_bcd_seq_display.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, segment constants and the shift-add-3 step for the sequential BCD display block.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_seq_display_seg7.sv
// Combinational single-digit BCD to active-low seven-segment decoder with blank override.
module seg7_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Codes A-F are not valid BCD and fall through to blank.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_LUT[digit];
        end
    end

endmodule

// File: rtl/bcd_seq_display.sv
// Iterative double-dabble binary-to-BCD converter driving DIGITS registered seven-segment outputs.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_seq_display #(
    parameter int unsigned N      = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);
    import bcd_pkg::*;

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SEG_W = 7 * DIGITS;

    function automatic logic [SEG_W-1:0] seg_reset_val();
        logic [SEG_W-1:0] v;
        v = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            v[7*k +: 7] = (k == 0) ? SEG_LUT[0] : SEG_BLANK;
`else
            v[7*k +: 7] = SEG_LUT[0];
`endif
        end
        return v;
    endfunction

    localparam logic [SEG_W-1:0] SEG_RST = seg_reset_val();

    state_t             state;
    state_t             state_nxt;
    logic [N-1:0]       shift_reg;
    logic [N-1:0]       shift_step;
    logic [BCD_W-1:0]   digits;
    logic [BCD_W-1:0]   digits_adj;
    logic [BCD_W-1:0]   digits_step;
    logic [BCD_W-1:0]   bcd_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_flag;
    logic               carry;
    logic               ovf_final;
    logic               accept;
    logic               step;
    logic               finish;
    logic [DIGITS-1:0]  blank;
    logic [SEG_W-1:0]   seg_nxt;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic               seen;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = start ? CONVERT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Start is only honoured outside CONVERT; the final step loads the outputs directly.
    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    accept = start;
            CONVERT: begin
                step   = 1'b1;
                finish = (cnt == '0);
            end
            DONE:    accept = start;
            default: ;
        endcase
    end

    // One shift-add-3 step; the bit leaving the top digit marks overflow.
    always_comb begin
        digits_adj = digits;
        for (int k = 0; k < int'(DIGITS); k++) begin
            digits_adj[4*k +: 4] = add3(digits[4*k +: 4]);
        end
        carry       = digits_adj[BCD_W-1];
        digits_step = {digits_adj[BCD_W-2:0], shift_reg[N-1]};
        shift_step  = shift_reg << 1;
        ovf_final   = ovf_flag | carry;
        bcd_nxt     = ovf_final ? {DIGITS{4'h9}} : digits_step;
    end

    // Running OR from the top digit down; digit 0 always shows.
    always_comb begin
        blank = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        seen  = 1'b0;
        for (int k = int'(DIGITS) - 1; k > 0; k--) begin
            seen     = seen | (bcd_nxt[4*k +: 4] != 4'd0);
            blank[k] = ~seen;
        end
`endif
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        seg7_decoder u_dec (
            .digit (bcd_nxt[4*k +: 4]),
            .blank (blank[k]),
            .seg   (seg_nxt[7*k +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            digits    <= '0;
            cnt       <= '0;
            ovf_flag  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bcd_out   <= '0;
            seg_out   <= SEG_RST;
        end else begin
            busy <= (state_nxt == CONVERT);
            done <= finish;
            if (accept) begin
                shift_reg <= bin_in;
                digits    <= '0;
                cnt       <= CNT_W'(N - 1);
                ovf_flag  <= 1'b0;
            end else if (step) begin
                shift_reg <= shift_step;
                digits    <= digits_step;
                cnt       <= cnt - CNT_W'(1);
                ovf_flag  <= ovf_final;
            end
            if (finish) begin
                overflow <= ovf_final;
                bcd_out  <= bcd_nxt;
                seg_out  <= seg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seq_display.sv
// Self-checking bench for bcd_seq_display: directed cases plus exhaustive and random sweeps
// against a decimal-arithmetic reference model, on 4-digit and 3-digit instances in parallel.
module tb_bcd_seq_display;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [N-1:0] bin_in;

    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [27:0] seg4;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [20:0] seg3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_seq_display #(.N(N), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy4), .done(done4), .overflow(ovf4), .bcd_out(bcd4), .seg_out(seg4)
    );

    bcd_seq_display #(.N(N), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .overflow(ovf3), .bcd_out(bcd3), .seg_out(seg3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p *= 10;
        return p;
    endfunction

    function automatic logic [63:0] m_bcd(input int x, input int d);
        logic [63:0] r = '0;
        int v = x;
        for (int k = 0; k < d; k++) begin
            if (x >= pow10(d)) r[4*k +: 4] = 4'h9;
            else begin
                r[4*k +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [63:0] m_seg(input logic [63:0] bcd, input int d);
        logic [63:0] r = '0;
        int msd = 0;
        for (int k = 0; k < d; k++) if (bcd[4*k +: 4] != 4'd0) msd = k;
        for (int k = 0; k < d; k++) begin
            r[7*k +: 7] = seg_of(bcd[4*k +: 4]);
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (k > msd) r[7*k +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    task automatic check_outputs(input int x);
        check("bcd4", 64'(bcd4), m_bcd(x, 4));
        check("seg4", 64'(seg4), m_seg(m_bcd(x, 4), 4));
        check("ovf4", 64'(ovf4), 64'(x >= 10000));
        check("bcd3", 64'(bcd3), m_bcd(x, 3));
        check("seg3", 64'(seg3), m_seg(m_bcd(x, 3), 3));
        check("ovf3", 64'(ovf3), 64'(x >= 1000));
    endtask

    // Launch one conversion; optional start pulses during CONVERT come from pulse_mask bits.
    task automatic run(input int x, input int pulse_mask);
        int lat;
        int bcnt;
        @(negedge clk);
        bin_in = N'(x);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done4 && lat < 40) begin
            if (busy4) bcnt++;
            start  = ((pulse_mask >> lat) & 1) != 0;
            bin_in = N'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(N));
        check("busy_cycles", 64'(bcnt), 64'(N));
        check("done3", 64'(done3), 64'd1);
        check("busy_at_done", 64'(busy4), 64'd0);
        check_outputs(x);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int gap;
        int seen;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_done", 64'(done4), 64'd0);
        check("rst_ovf", 64'(ovf4), 64'd0);
        check("rst_bcd4", 64'(bcd4), 64'd0);
        check("rst_seg4", 64'(seg4), m_seg(64'd0, 4));
        check("rst_seg3", 64'(seg3), m_seg(64'd0, 3));
        @(negedge clk);
        rst = 1'b0;

        run(999, 0);
        check("bcd_999", 64'(bcd4), 64'h0999);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("seg_999", 64'(seg4), 64'({7'h7F, 7'h10, 7'h10, 7'h10}));
`else
        check("seg_999", 64'(seg4), 64'({7'h40, 7'h10, 7'h10, 7'h10}));
`endif
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done4), 64'd0);

        run(1023, 0);
        check("bcd_1023", 64'(bcd4), 64'h1023);
        check("seg_1023", 64'(seg4), 64'({7'h79, 7'h40, 7'h24, 7'h30}));
        run(0, 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("seg_0", 64'(seg4), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
`else
        check("seg_0", 64'(seg4), 64'({7'h40, 7'h40, 7'h40, 7'h40}));
`endif

        run(1000, 0);
        check("ovf3_1000", 64'(ovf3), 64'd1);
        check("bcd3_1000", 64'(bcd3), 64'h999);
        run(42, 0);
        check("ovf3_42", 64'(ovf3), 64'd0);
        check("bcd3_42", 64'(bcd3), 64'h042);

        // Start pulses mid-conversion are ignored.
        run(555, (1 << 3) | (1 << 7));

        // Start held through DONE restarts exactly one period later.
        start  = 1'b1;
        bin_in = N'(321);
        gap    = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!done4 && gap < 40);
        start = 1'b0;
        check("held_start_gap", 64'(gap), 64'(N + 1));
        check_outputs(321);
        @(posedge clk);
        #1;
        check("idle_after_done", 64'(done4 | busy4), 64'd0);

        // Reset in the middle of a conversion aborts it.
        run(1000, 0);
        @(negedge clk);
        bin_in = N'(700);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy4), 64'd0);
        check("abort_done", 64'(done4), 64'd0);
        check("abort_bcd", 64'(bcd4), 64'd0);
        check("abort_seg", 64'(seg4), m_seg(64'd0, 4));
        check("abort_ovf3", 64'(ovf3), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) seen = 1;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        run(700, 0);

        for (int x = 0; x < (1 << N); x++) run(x, 0);

        repeat (200) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            run(int'($urandom_range(0, (1 << N) - 1)), int'($urandom_range(0, 1023)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
